// File: rtl/score_pkg.sv
// Shared definitions for the player status register file: update op codes,
// word field layout, BCD limits and update FSM state encodings.
package score_pkg;

  typedef enum logic [1:0] {
    OP_ADD_SCORE    = 2'b00,
    OP_DAMAGE       = 2'b01,
    OP_HEAL         = 2'b10,
    OP_RESET_PLAYER = 2'b11
  } upd_op_e;

  localparam int LIVES_LSB  = 28;
  localparam int LIVES_W    = 4;
  localparam int HEALTH_LSB = 20;
  localparam int HEALTH_W   = 8;
  localparam int SCORE_LSB  = 0;
  localparam int SCORE_W    = 20;
  localparam int NUM_DIGITS = 5;

  localparam logic [19:0] BCD_MAX = 20'h99999;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ADD    = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  function automatic logic [3:0] get_lives(input logic [31:0] w);
    return w[LIVES_LSB +: LIVES_W];
  endfunction

  function automatic logic [7:0] get_health(input logic [31:0] w);
    return w[HEALTH_LSB +: HEALTH_W];
  endfunction

  function automatic logic [19:0] get_score(input logic [31:0] w);
    return w[SCORE_LSB +: SCORE_W];
  endfunction

  function automatic logic [31:0] pack_word(input logic [3:0] lives, input logic [7:0] health,
                                            input logic [19:0] score);
    logic [31:0] w;
    w = '0;
    w[LIVES_LSB +: LIVES_W]   = lives;
    w[HEALTH_LSB +: HEALTH_W] = health;
    w[SCORE_LSB +: SCORE_W]   = score;
    return w;
  endfunction

  function automatic logic is_bcd(input logic [19:0] v);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (v[4*d +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/score_regfile_if.sv
// Score-read and player-update bus between game logic / renderer (master)
// and the player register file (slave).
interface score_regfile_if;
  logic        score_re;
  logic [4:0]  score_addr;
  logic [31:0] score_data;
  logic        score_valid_data;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_player;
  logic [1:0]  upd_op;
  logic [19:0] upd_arg;

  modport master (
    output score_re, score_addr, upd_valid, upd_player, upd_op, upd_arg,
    input  score_data, score_valid_data, upd_ready
  );

  modport slave (
    input  score_re, score_addr, upd_valid, upd_player, upd_op, upd_arg,
    output score_data, score_valid_data, upd_ready
  );
endinterface

// File: rtl/bcd_digit_add.sv
// Single packed-BCD digit adder with carry; combinational, reused serially
// across the five score digits.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  // NOTE: every output of a combinational block is given a value on every
  // path, otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    raw = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    if (raw > 5'd9) begin
      sum  = raw[3:0] + 4'd6;
      cout = 1'b1;
    end else begin
      sum  = raw[3:0];
      cout = 1'b0;
    end
  end
endmodule

// File: rtl/score_regfile.sv
// Player status register file with a digit-serial BCD score adder.
// Optional SCORE_BCD_CHECK_EN: reject non-BCD ADD_SCORE operands via upd_err.
module score_regfile
  import score_pkg::*;
#(
  parameter int          NUM_PLAYERS = 4,
  parameter int          READ_LAT    = 2,
  parameter logic [3:0]  INIT_LIVES  = 4'd3,
  parameter logic [7:0]  MAX_HEALTH  = 8'd100
) (
  input  logic                   clk,
  input  logic                   rst,
  score_regfile_if.slave         bus,
  output logic [NUM_PLAYERS-1:0] player_alive,
`ifdef SCORE_BCD_CHECK_EN
  output logic                   upd_err,
`endif
  output logic                   all_dead
);

  localparam int          CNT_W      = $clog2(READ_LAT + 1);
  localparam logic [31:0] RESET_WORD = pack_word(INIT_LIVES, MAX_HEALTH, 20'h0);

  logic [31:0] regs [NUM_PLAYERS];

  // ---------------- read path ----------------
  logic             rd_pending;
  logic [CNT_W-1:0] rd_cnt;
  logic [31:0]      rd_word_q;
  logic [31:0]      rd_word_c;
  logic             rd_accept;

  always_comb begin
    rd_word_c = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (bus.score_addr == 5'(i)) rd_word_c = regs[i];
    end
  end

  assign rd_accept = bus.score_re && !rd_pending && !bus.score_valid_data;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending           <= 1'b0;
      rd_cnt               <= '0;
      rd_word_q            <= '0;
      bus.score_valid_data <= 1'b0;
      bus.score_data       <= '0;
    end else begin
      bus.score_valid_data <= 1'b0;
      bus.score_data       <= '0;
      if (rd_accept) begin
        if (READ_LAT == 1) begin
          bus.score_valid_data <= 1'b1;
          bus.score_data       <= rd_word_c;
        end else begin
          rd_pending <= 1'b1;
          rd_cnt     <= CNT_W'(READ_LAT - 1);
          rd_word_q  <= rd_word_c;
        end
      end else if (rd_pending) begin
        rd_cnt <= rd_cnt - 1'b1;
        if (rd_cnt == CNT_W'(1)) begin
          rd_pending           <= 1'b0;
          bus.score_valid_data <= 1'b1;
          bus.score_data       <= rd_word_q;
        end
      end
    end
  end

  // ---------------- update FSM ----------------
  logic [1:0]  state;
  logic [2:0]  player_q;
  upd_op_e     op_q;
  logic [19:0] arg_q;
  logic [19:0] acc_q;
  logic        carry_q;
  logic [2:0]  digit_q;
  logic        sat_q;
  logic        commit_en;
  logic [31:0] cur_word_c;
  logic [31:0] upd_word_c;
  logic [3:0]  base_digit;
  logic [3:0]  dig_sum;
  logic        dig_cout;

  assign bus.upd_ready = (state == ST_IDLE);

  always_comb begin
    cur_word_c = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (player_q == 3'(i)) cur_word_c = regs[i];
    end
  end

  always_comb begin
    base_digit = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_q == 3'(d)) base_digit = get_score(cur_word_c)[4*d +: 4];
    end
  end

  bcd_digit_add u_digit_add (
    .a   (base_digit),
    .b   (arg_q[3:0]),
    .cin (carry_q),
    .sum (dig_sum),
    .cout(dig_cout)
  );

  always_comb begin
    logic [3:0]  lives;
    logic [7:0]  health;
    logic [19:0] score;
    logic [8:0]  heal_sum;
    lives    = get_lives(cur_word_c);
    health   = get_health(cur_word_c);
    score    = get_score(cur_word_c);
    heal_sum = {1'b0, health} + {1'b0, arg_q[7:0]};
    case (op_q)
      OP_ADD_SCORE: score = sat_q ? BCD_MAX : acc_q;
      OP_DAMAGE: begin
        if (health > arg_q[7:0]) begin
          health = health - arg_q[7:0];
        end else if (lives != 4'd0) begin
          lives  = lives - 4'd1;
          health = MAX_HEALTH;
        end else begin
          health = 8'd0;
        end
      end
      OP_HEAL: begin
        if (lives != 4'd0 || health != 8'd0)
          health = (heal_sum > {1'b0, MAX_HEALTH}) ? MAX_HEALTH : heal_sum[7:0];
      end
      default: begin
        lives  = INIT_LIVES;
        health = MAX_HEALTH;
        score  = 20'h0;
      end
    endcase
    upd_word_c = pack_word(lives, health, score);
  end

`ifdef SCORE_BCD_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst)                                   err_q <= 1'b0;
    else if (state == ST_IDLE && bus.upd_valid) err_q <= (bus.upd_op == OP_ADD_SCORE) && !is_bcd(bus.upd_arg);
  end

  assign upd_err   = (state == ST_COMMIT) && err_q;
  assign commit_en = !err_q;
`else
  assign commit_en = 1'b1;
`endif

  // Operands are shifted down one digit per cycle; the partial sum enters
  // from the top so it is in digit order after the fifth step.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      player_q <= '0;
      op_q     <= OP_ADD_SCORE;
      arg_q    <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      digit_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.upd_valid) begin
            player_q <= bus.upd_player;
            op_q     <= upd_op_e'(bus.upd_op);
            arg_q    <= bus.upd_arg;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            digit_q  <= '0;
            sat_q    <= 1'b0;
            state    <= (bus.upd_op == OP_ADD_SCORE) ? ST_ADD : ST_COMMIT;
          end
        end
        ST_ADD: begin
          acc_q   <= {dig_sum, acc_q[19:4]};
          arg_q   <= {4'h0, arg_q[19:4]};
          carry_q <= dig_cout;
          digit_q <= digit_q + 3'd1;
          if (digit_q == 3'(NUM_DIGITS - 1)) begin
            sat_q <= dig_cout;
            state <= ST_COMMIT;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the register array is reset explicitly because every player must
  // come out of reset with a defined status word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PLAYERS; i++) regs[i] <= RESET_WORD;
    end else if (state == ST_COMMIT && commit_en) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (player_q == 3'(i)) regs[i] <= upd_word_c;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      player_alive[i] = (get_lives(regs[i]) != 4'd0) || (get_health(regs[i]) != 8'd0);
    end
    all_dead = ~|player_alive;
  end

endmodule

// File: tb/tb_score_regfile.sv
// Self-checking bench for score_regfile: update/read vector table with a read
// scoreboard, plus concurrent read/update and mid-operation reset sequences.
module tb_score_regfile;
  import score_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  score_regfile_if bus ();
  logic [3:0] player_alive;
  logic       all_dead;
`ifdef SCORE_BCD_CHECK_EN
  logic       upd_err;
`endif

  score_regfile #(
    .NUM_PLAYERS(4),
    .READ_LAT   (2),
    .INIT_LIVES (4'd3),
    .MAX_HEALTH (8'd100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .player_alive(player_alive),
`ifdef SCORE_BCD_CHECK_EN
    .upd_err     (upd_err),
`endif
    .all_dead    (all_dead)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pulse_cnt = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  player;
    logic [1:0]  op;
    logic [19:0] arg;
    logic [4:0]  rd_addr;
    logic [31:0] exp_word;
    logic [3:0]  exp_alive;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every read pulse is matched against the oldest expected word.
  always @(negedge clk) begin
    if (bus.score_valid_data === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) check("spurious_pulse", 32'(bus.score_valid_data), 32'd0);
      else                   check("read_data", bus.score_data, exp_q.pop_front());
    end
  end

  task automatic do_read(input logic [4:0] addr, input logic [31:0] exp, input int delay);
    int lat;
    int p0;
    repeat (delay) @(posedge clk);
    #1;
    p0 = pulse_cnt;
    bus.score_re   = 1'b1;
    bus.score_addr = addr;
    exp_q.push_back(exp);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (bus.score_valid_data !== 1'b1 && lat < 10);
    bus.score_re = 1'b0;
    check("read_latency", 32'(lat), 32'd2);
    @(posedge clk);
    #1;
    check("data_cleared", bus.score_data, 32'd0);
    check("single_pulse", 32'(pulse_cnt - p0), 32'd1);
  endtask

  task automatic do_update(input logic [2:0] player, input logic [1:0] op, input logic [19:0] arg);
    int n;
    n = 0;
    while (bus.upd_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("ready_idle", 32'(bus.upd_ready), 32'd1);
    bus.upd_valid  = 1'b1;
    bus.upd_player = player;
    bus.upd_op     = op;
    bus.upd_arg    = arg;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    n = 0;
    while (bus.upd_ready !== 1'b1 && n < 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("ready_low_cycles", 32'(n), (op == OP_ADD_SCORE) ? 32'd6 : 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    rst            = 1'b1;
    bus.score_re   = 1'b0;
    bus.score_addr = '0;
    bus.upd_valid  = 1'b0;
    bus.upd_player = '0;
    bus.upd_op     = '0;
    bus.upd_arg    = '0;

    vecs[0]  = '{3'd1, OP_ADD_SCORE,    20'h00795, 5'd1, 32'h3640_0795, 4'hF};
    vecs[1]  = '{3'd1, OP_ADD_SCORE,    20'h00795, 5'd1, 32'h3640_1590, 4'hF};
    vecs[2]  = '{3'd1, OP_ADD_SCORE,    20'h99999, 5'd1, 32'h3649_9999, 4'hF};
    vecs[3]  = '{3'd2, OP_DAMAGE,       20'd100,   5'd2, 32'h2640_0000, 4'hF};
    vecs[4]  = '{3'd2, OP_DAMAGE,       20'd100,   5'd2, 32'h1640_0000, 4'hF};
    vecs[5]  = '{3'd2, OP_DAMAGE,       20'd100,   5'd2, 32'h0640_0000, 4'hF};
    vecs[6]  = '{3'd2, OP_DAMAGE,       20'd100,   5'd2, 32'h0000_0000, 4'hB};
    vecs[7]  = '{3'd2, OP_HEAL,         20'd50,    5'd2, 32'h0000_0000, 4'hB};
    vecs[8]  = '{3'd0, OP_DAMAGE,       20'd30,    5'd0, 32'h3460_0000, 4'hB};
    vecs[9]  = '{3'd0, OP_HEAL,         20'd50,    5'd0, 32'h3640_0000, 4'hB};
    vecs[10] = '{3'd3, OP_ADD_SCORE,    20'h09999, 5'd3, 32'h3640_9999, 4'hB};
    vecs[11] = '{3'd3, OP_ADD_SCORE,    20'h00001, 5'd3, 32'h3641_0000, 4'hB};
    vecs[12] = '{3'd1, OP_RESET_PLAYER, 20'h0,     5'd1, 32'h3640_0000, 4'hB};
    vecs[13] = '{3'd2, OP_RESET_PLAYER, 20'h0,     5'd2, 32'h3640_0000, 4'hF};
    vecs[14] = '{3'd0, OP_DAMAGE,       20'd5,     5'd0, 32'h35F0_0000, 4'hF};
    vecs[15] = '{3'd5, OP_ADD_SCORE,    20'h00001, 5'd5, 32'h0000_0000, 4'hF};
    vecs[16] = '{3'd0, OP_HEAL,         20'd5,     5'd0, 32'h3640_0000, 4'hF};
    vecs[17] = '{3'd0, OP_ADD_SCORE,    20'h00001, 5'd0, 32'h3640_0001, 4'hF};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.score_valid_data), 32'd0);
    check("rst_data", bus.score_data, 32'd0);
    check("rst_ready", 32'(bus.upd_ready), 32'd1);
    rst = 1'b0;
    check("rst_alive", 32'(player_alive), 32'hF);
    check("rst_all_dead", 32'(all_dead), 32'd0);
    for (int a = 0; a < 4; a++) do_read(5'(a), 32'h3640_0000, 0);
    do_read(5'd7, 32'h0, 0);

    for (int i = 0; i < 18; i++) begin
      do_update(vecs[i].player, vecs[i].op, vecs[i].arg);
      check("alive", 32'(player_alive), 32'(vecs[i].exp_alive));
      do_read(vecs[i].rd_addr, vecs[i].exp_word, 0);
    end

    // Reads racing an ADD_SCORE to the same player: mid-add, at commit edge, after commit.
    fork
      do_update(3'd3, OP_ADD_SCORE, 20'h00002);
      do_read(5'd3, 32'h3641_0000, 3);
    join
    fork
      do_update(3'd3, OP_ADD_SCORE, 20'h00002);
      do_read(5'd3, 32'h3641_0002, 6);
    join
    fork
      do_update(3'd3, OP_ADD_SCORE, 20'h00002);
      do_read(5'd3, 32'h3641_0006, 7);
    join

`ifdef SCORE_BCD_CHECK_EN
    bus.upd_valid  = 1'b1;
    bus.upd_player = 3'd0;
    bus.upd_op     = OP_ADD_SCORE;
    bus.upd_arg    = 20'h0000A;
    repeat (6) @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    check("upd_err_pulse", 32'(upd_err), 32'd1);
    @(posedge clk);
    #1;
    check("upd_err_clear", 32'(upd_err), 32'd0);
    do_read(5'd0, 32'h3640_0001, 0);
`endif

    // Drain every player; all_dead only once the last one falls.
    for (int p = 0; p < 4; p++) begin
      if (p == 3) check("not_all_dead", 32'(all_dead), 32'd0);
      repeat (4) do_update(3'(p), OP_DAMAGE, 20'd255);
    end
    check("dead_alive", 32'(player_alive), 32'h0);
    check("all_dead", 32'(all_dead), 32'd1);

    // Reset three cycles into an ADD_SCORE with a read pending.
    p0 = pulse_cnt;
    bus.upd_valid  = 1'b1;
    bus.upd_player = 3'd0;
    bus.upd_op     = OP_ADD_SCORE;
    bus.upd_arg    = 20'h00001;
    @(posedge clk);
    #1;
    bus.upd_valid = 1'b0;
    @(posedge clk);
    #1;
    bus.score_re   = 1'b1;
    bus.score_addr = 5'd0;
    @(posedge clk);
    #1;
    bus.score_re = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", 32'(bus.score_valid_data), 32'd0);
    check("midrst_ready", 32'(bus.upd_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    check("midrst_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check("midrst_ready_held", 32'(bus.upd_ready), 32'd1);
    check("midrst_alive", 32'(player_alive), 32'hF);
    for (int a = 0; a < 4; a++) do_read(5'(a), 32'h3640_0000, 0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
